mdu_sequencer: RTL

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It sits beside the EX stage and accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per request. It models the iterative unit's latency with a down-counter and drives the `busy` signal that the stall unit combines with the ID-stage mult-type decode. MFHI/MFLO read the `hi`/`lo` outputs directly in EX.

---
 rtl/mdu_if.sv | 22 ++
 rtl/mdu_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// Command/result bundle between the EX stage (master) and the HI/LO sequencer (slave).
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer owning HI/LO; a down-counter models the iterative unit's latency.
// Define MDU_DIV_EN to build DIV/DIVU; without it op codes 2/3 are reserved like 6/7.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_p0;
    logic [31:0]        rs_p0, rt_p0;
    logic [31:0]        hi_q, lo_q;
    logic               is_mul, is_div, is_mt;
    logic               accept, acc_long, acc_mt;
    logic               busy_c, done_c;
    logic [63:0]        res_p0;
    logic               wr_p0;

    function automatic logic [63:0] mul_result(input logic sgn, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic        [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        sp = sa * sb;
        if (sgn)
            return sp;
        return ua * ub;
    endfunction

`ifdef MDU_DIV_EN
    // Returns {remainder, quotient}; the one signed overflow case is pinned explicitly.
    function automatic logic [63:0] div_result(input logic sgn, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        sa = a;
        sb = b;
        if (!sgn)
            return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
    endfunction
`endif

    always_comb begin
        is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef MDU_DIV_EN
        is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`else
        is_div = 1'b0;
`endif
        is_mt  = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
    end

    assign accept   = bus.start & ~bus.flush & (state_q == IDLE);
    assign acc_long = accept & (is_mul | is_div);
    assign acc_mt   = accept & is_mt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_long) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state_q == RUN);
        done_c = (state_q == RUN) && (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (acc_long)
            cnt_q <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (state_q == RUN)
            cnt_q <= cnt_q - CNT_W'(1);
    end

    // Stage p0: operands captured at accept; later EX-stage changes are invisible.
    always_ff @(posedge clk) begin
        if (acc_long) begin
            op_p0 <= bus.op;
            rs_p0 <= bus.rs_data;
            rt_p0 <= bus.rt_data;
        end
    end

    always_comb begin
        res_p0 = {hi_q, lo_q};
        wr_p0  = 1'b0;
        case (op_p0)
            OP_MULT, OP_MULTU: begin
                res_p0 = mul_result(op_p0 == OP_MULT, rs_p0, rt_p0);
                wr_p0  = 1'b1;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
                if (rt_p0 != 32'd0) begin
                    res_p0 = div_result(op_p0 == OP_DIV, rs_p0, rt_p0);
                    wr_p0  = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // HI/LO commit: long ops at their final busy edge, moves at the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (done_c && wr_p0) begin
            hi_q <= res_p0[63:32];
            lo_q <= res_p0[31:0];
        end else if (acc_mt) begin
            if (bus.op == OP_MTHI)
                hi_q <= bus.rs_data;
            else
                lo_q <= bus.rs_data;
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
